// File: rtl/hdmi_cfg_pkg.sv
// Shared types and the default register-write table for the HDMI transmitter
// configuration sequencer.
package hdmi_cfg_pkg;

  typedef enum logic [2:0] {
    S_WAIT_HPD,
    S_ISSUE,
    S_WAIT_RESP,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } entry_t;

  localparam int unsigned DEFAULT_NUM_REGS = 20;

  // Power-up first, then fixed registers, then video setup.
  function automatic entry_t default_entry(input int unsigned idx);
    entry_t e;
    case (idx)
      0:       e = '{8'h41, 8'h10};
      1:       e = '{8'h98, 8'h03};
      2:       e = '{8'h9A, 8'hE0};
      3:       e = '{8'h9C, 8'h30};
      4:       e = '{8'h9D, 8'h61};
      5:       e = '{8'hA2, 8'hA4};
      6:       e = '{8'hA3, 8'hA4};
      7:       e = '{8'hE0, 8'hD0};
      8:       e = '{8'hF9, 8'h00};
      9:       e = '{8'h15, 8'h00};
      10:      e = '{8'h16, 8'h30};
      11:      e = '{8'h17, 8'h02};
      12:      e = '{8'h18, 8'h46};
      13:      e = '{8'hAF, 8'h04};
      14:      e = '{8'h55, 8'h10};
      15:      e = '{8'h56, 8'h08};
      16:      e = '{8'h96, 8'hF6};
      17:      e = '{8'h73, 8'h01};
      18:      e = '{8'h76, 8'h1F};
      19:      e = '{8'hD6, 8'hC0};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Combinational index-to-entry lookup; swap this file to change the table.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned IDX_W    = 5
) (
  input  logic [IDX_W-1:0] idx_i,
  output entry_t           entry_o
);

  always_comb begin
    entry_o = '0;
    if (32'(idx_i) < NUM_REGS) entry_o = default_entry(32'(idx_i));
  end

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// HDMI transmitter configuration sequencer: qualifies hot-plug, then writes
// the register table through the I2C byte master with NACK retries.
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 20,
  parameter logic [6:0]  SLAVE_ADDR = 7'h39,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned HPD_STABLE = 1024,
  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             CLK_I2C,
  input  logic             RST_n,
  input  logic             START,
  input  logic             HPD,
  output logic             WR_VALID,
  input  logic             WR_READY,
  output logic [6:0]       WR_SLAVE,
  output logic [7:0]       WR_REG,
  output logic [7:0]       WR_DATA,
  input  logic             RESP_VALID,
  input  logic             RESP_NACK,
  output logic             BUSY,
  output logic             CFG_DONE,
  output logic             CFG_ERR,
  output logic [IDX_W-1:0] CUR_IDX
);

  localparam int unsigned HPD_W = (HPD_STABLE > 1) ? $clog2(HPD_STABLE) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [HPD_W-1:0] HPD_LAST = HPD_W'(HPD_STABLE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [HPD_W-1:0]   hpd_cnt_q, hpd_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               pend_q, pend_d;
  logic               hpd_stable, abort_req, restart, advance, issue;
  entry_t             entry;

  hdmi_cfg_rom #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_rom (
    .idx_i   (idx_q),
    .entry_o (entry)
  );

  // Stability counter runs in every state so a START with HPD already
  // qualified re-enters ISSUE without another full qualification window.
  always_comb begin
    hpd_cnt_d = hpd_cnt_q;
    if (!HPD)                      hpd_cnt_d = '0;
    else if (hpd_cnt_q != HPD_LAST) hpd_cnt_d = hpd_cnt_q + HPD_W'(1);
  end

  assign hpd_stable = HPD && (hpd_cnt_q == HPD_LAST);
  assign abort_req  = START || !HPD;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    restart = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_WAIT_HPD: begin
        if (START)           restart = 1'b1;
        else if (hpd_stable) state_d = S_ISSUE;
      end
      // An accepted request is never abandoned; an abort in the same cycle
      // becomes pending and is applied when the response arrives.
      S_ISSUE: begin
        if (WR_READY) begin
          state_d = S_WAIT_RESP;
          pend_d  = abort_req;
        end else if (abort_req) begin
          restart = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (RESP_VALID) begin
          if (pend_q || abort_req) begin
            restart = 1'b1;
          end else if (RESP_NACK) begin
            if (retry_q == RTY_MAX) state_d = S_ERROR;
            else begin
              retry_d = retry_q + RTY_W'(1);
              advance = 1'b1;
            end
          end else begin
            retry_d = '0;
            if (idx_q == IDX_LAST) state_d = S_DONE;
            else begin
              idx_d   = idx_q + IDX_W'(1);
              advance = 1'b1;
            end
          end
        end else if (abort_req) begin
          pend_d = 1'b1;
        end
      end
      S_GAP: begin
        if (abort_req)              restart = 1'b1;
        else if (gap_q == GAP_LAST) state_d = S_ISSUE;
        else                        gap_d   = gap_q + GAP_W'(1);
      end
      S_DONE, S_ERROR: begin
        if (abort_req) restart = 1'b1;
      end
      default: restart = 1'b1;
    endcase
    if (advance) begin
      gap_d   = '0;
      state_d = (GAP_CYCLES == 0) ? S_ISSUE : S_GAP;
    end
    if (restart) begin
      state_d = S_WAIT_HPD;
      idx_d   = '0;
      retry_d = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_I2C or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_WAIT_HPD;
      idx_q     <= '0;
      retry_q   <= '0;
      hpd_cnt_q <= '0;
      gap_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      hpd_cnt_q <= hpd_cnt_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
    end
  end

  assign issue    = (state_q == S_ISSUE);
  assign WR_VALID = issue;
  assign WR_SLAVE = issue ? SLAVE_ADDR     : '0;
  assign WR_REG   = issue ? entry.reg_addr : '0;
  assign WR_DATA  = issue ? entry.data     : '0;
  assign BUSY     = issue || (state_q == S_WAIT_RESP) || (state_q == S_GAP);
  assign CFG_DONE = (state_q == S_DONE);
  assign CFG_ERR  = (state_q == S_ERROR);
  assign CUR_IDX  = idx_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Self-checking bench: scoreboard of expected writes, a latency-5 responder
// driven by a NACK plan, and hand sequences for retry/HPD/reset corners.
module tb_hdmi_cfg_sequencer;

  localparam int RESP_LAT = 5;

  logic       clk, RST_n, START, HPD, WR_READY, RESP_VALID, RESP_NACK;
  logic       WR_VALID, BUSY, CFG_DONE, CFG_ERR;
  logic [6:0] WR_SLAVE;
  logic [7:0] WR_REG, WR_DATA;
  logic [4:0] CUR_IDX;

  hdmi_cfg_sequencer #(
    .NUM_REGS   (20),
    .SLAVE_ADDR (7'h39),
    .MAX_RETRY  (3),
    .GAP_CYCLES (2),
    .HPD_STABLE (8)
  ) dut (
    .CLK_I2C    (clk),
    .RST_n      (RST_n),
    .START      (START),
    .HPD        (HPD),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_SLAVE   (WR_SLAVE),
    .WR_REG     (WR_REG),
    .WR_DATA    (WR_DATA),
    .RESP_VALID (RESP_VALID),
    .RESP_NACK  (RESP_NACK),
    .BUSY       (BUSY),
    .CFG_DONE   (CFG_DONE),
    .CFG_ERR    (CFG_ERR),
    .CUR_IDX    (CUR_IDX)
  );

  typedef struct { logic [7:0] r; logic [7:0] d; } vec_t;
  typedef struct { int unsigned idx; logic [7:0] r; logic [7:0] d; } exp_t;

  vec_t tbl [20];
  exp_t exp_q[$];
  bit   nack_q[$];
  int   acc_cyc[$];
  int   total = 0, bad = 0;
  int   cyc = 0, acc_n = 0, resp_cnt = 0;
  bit   acc_flag = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard: every accepted write is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (RST_n && WR_VALID && WR_READY) begin
      acc_n++;
      acc_cyc.push_back(cyc);
      acc_flag = 1;
      if (exp_q.size() == 0) check("unexpected_wr", 32'(WR_REG), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("wr_reg", 32'(WR_REG), 32'(e.r));
        check("wr_data", 32'(WR_DATA), 32'(e.d));
        check("wr_idx", 32'(CUR_IDX), e.idx);
        check("wr_slave", 32'(WR_SLAVE), 32'h39);
      end
    end
  end

  // Response is sampled RESP_LAT edges after acceptance.
  initial begin
    RESP_VALID = 0;
    RESP_NACK  = 0;
    forever begin
      @(posedge clk); #1;
      RESP_VALID = 0;
      RESP_NACK  = 0;
      if (!RST_n) begin
        resp_cnt = 0;
        acc_flag = 0;
      end else if (acc_flag) begin
        acc_flag = 0;
        resp_cnt = RESP_LAT - 1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          RESP_VALID = 1;
          RESP_NACK  = (nack_q.size() != 0) ? nack_q.pop_front() : 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back('{i, tbl[i].r, tbl[i].d});
  endtask

  task automatic pulse_start();
    START = 1; tick(1); START = 0;
  endtask

  task automatic wait_acc(input int target, input string nm);
    int n = 0;
    while (acc_n < target && n < 400) begin tick(1); n++; end
    check(nm, 32'(acc_n >= target), 32'd1);
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (!(CFG_DONE || CFG_ERR) && n < 600) begin tick(1); n++; end
    check(nm, 32'(CFG_DONE || CFG_ERR), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(WR_VALID), 0);
    check({tag, "_slave"}, 32'(WR_SLAVE), 0);
    check({tag, "_reg"},   32'(WR_REG),   0);
    check({tag, "_data"},  32'(WR_DATA),  0);
    check({tag, "_busy"},  32'(BUSY),     0);
    check({tag, "_done"},  32'(CFG_DONE), 0);
    check({tag, "_err"},   32'(CFG_ERR),  0);
    check({tag, "_idx"},   32'(CUR_IDX),  0);
  endtask

  initial begin
    int base, rel, rise, k;
    tbl = '{'{8'h41, 8'h10}, '{8'h98, 8'h03}, '{8'h9A, 8'hE0}, '{8'h9C, 8'h30},
            '{8'h9D, 8'h61}, '{8'hA2, 8'hA4}, '{8'hA3, 8'hA4}, '{8'hE0, 8'hD0},
            '{8'hF9, 8'h00}, '{8'h15, 8'h00}, '{8'h16, 8'h30}, '{8'h17, 8'h02},
            '{8'h18, 8'h46}, '{8'hAF, 8'h04}, '{8'h55, 8'h10}, '{8'h56, 8'h08},
            '{8'h96, 8'hF6}, '{8'h73, 8'h01}, '{8'h76, 8'h1F}, '{8'hD6, 8'hC0}};
    RST_n = 0; START = 0; HPD = 1; WR_READY = 1;

    // T1: reset values, then the full table in order
    tick(3);
    check_zero("rst");
    push_range(0, 19);
    RST_n = 1;
    rel = cyc;
    wait_end("t1_end");
    check("t1_done", 32'(CFG_DONE), 1);
    check("t1_err", 32'(CFG_ERR), 0);
    check("t1_busy", 32'(BUSY), 0);
    check("t1_idx", 32'(CUR_IDX), 19);
    check("t1_count", acc_n, 20);
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_first_cyc", acc_cyc[0] - rel, 8);
    check("t1_period", acc_cyc[1] - acc_cyc[0], 8);
    check("t1_period_last", acc_cyc[19] - acc_cyc[18], 8);
    tick(30);
    check("t1_no_more_wr", acc_n, 20);
    check("t1_done_hold", 32'(CFG_DONE), 1);

    // T2: one-cycle HPD drop in DONE, then entry 3 NACKed twice
    base = acc_n;
    HPD = 0; tick(1); HPD = 1;
    check("t2_done_clr", 32'(CFG_DONE), 0);
    check("t2_idx_clr", 32'(CUR_IDX), 0);
    nack_q = '{0, 0, 0, 1, 1};
    push_range(0, 3); push_range(3, 3); push_range(3, 19);
    wait_end("t2_end");
    check("t2_done", 32'(CFG_DONE), 1);
    check("t2_err", 32'(CFG_ERR), 0);
    check("t2_count", acc_n - base, 22);
    check("t2_sb_empty", exp_q.size(), 0);

    // T3: entry 5 NACKed four times -> error, then START re-runs
    base = acc_n;
    nack_q = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    push_range(0, 5); push_range(5, 5); push_range(5, 5); push_range(5, 5);
    pulse_start();
    wait_end("t3_end");
    check("t3_err", 32'(CFG_ERR), 1);
    check("t3_done", 32'(CFG_DONE), 0);
    check("t3_busy", 32'(BUSY), 0);
    check("t3_idx", 32'(CUR_IDX), 5);
    check("t3_count", acc_n - base, 9);
    tick(20);
    check("t3_err_hold", 32'(CFG_ERR), 1);
    check("t3_no_more_wr", acc_n - base, 9);
    base = acc_n;
    push_range(0, 19);
    pulse_start();
    check("t3_err_clr", 32'(CFG_ERR), 0);
    wait_end("t3_rerun_end");
    check("t3_rerun_done", 32'(CFG_DONE), 1);
    check("t3_rerun_count", acc_n - base, 20);
    check("t3_sb_empty", exp_q.size(), 0);

    // T4: HPD low 3 cycles while entry 7 awaits its response
    base = acc_n;
    push_range(0, 7); push_range(0, 19);
    pulse_start();
    wait_acc(base + 8, "t4_reach_e7");
    k = acc_cyc.size();
    HPD = 0; tick(3); HPD = 1;
    rise = cyc;
    check("t4_no_wr_during_drop", acc_n - base, 8);
    wait_acc(base + 9, "t4_restart");
    check("t4_requal_cyc", acc_cyc[k] - rise, 8);
    wait_end("t4_end");
    check("t4_done", 32'(CFG_DONE), 1);
    check("t4_count", acc_n - base, 28);
    check("t4_sb_empty", exp_q.size(), 0);

    // T5: WR_READY low 10 cycles -> request held stable, accepted once
    base = acc_n;
    WR_READY = 0;
    push_range(0, 19);
    pulse_start();
    k = 0;
    while (!WR_VALID && k < 50) begin tick(1); k++; end
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", 32'(WR_VALID), 1);
      check("t5_hold_reg", 32'(WR_REG), 32'h41);
      check("t5_hold_data", 32'(WR_DATA), 32'h10);
      tick(1);
    end
    check("t5_no_accept", acc_n - base, 0);
    WR_READY = 1;
    wait_end("t5_end");
    check("t5_done", 32'(CFG_DONE), 1);
    check("t5_count", acc_n - base, 20);
    check("t5_sb_empty", exp_q.size(), 0);

    // T6: asynchronous reset while entry 2 awaits its response
    push_range(0, 19);
    pulse_start();
    wait_acc(acc_n + 3, "t6_reach_e2");
    check("t6_busy_before", 32'(BUSY), 1);
    #2 RST_n = 0;
    #1 check_zero("t6_async");
    tick(2);
    exp_q.delete(); nack_q.delete(); acc_cyc.delete();
    base = acc_n;
    push_range(0, 19);
    RST_n = 1;
    rel = cyc;
    wait_end("t6_end");
    check("t6_requal_cyc", acc_cyc[0] - rel, 8);
    check("t6_done", 32'(CFG_DONE), 1);
    check("t6_count", acc_n - base, 20);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
